axi_sram_wr_ctrl: RTL and testbench

- AXI4 write-channel slave stage that sits directly in front of the SRAM model.
- Accepts one AW burst at a time, then consumes the W beats of that burst.
- Per beat, computes the beat address and the active byte lanes, using the team's AXI aligned-address, byte-lane and wrap-boundary rules.
- Issues a masked single-cycle SRAM write per beat, then returns a B response.

---
 rtl/axi_sram_wr_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_axi_sram_wr_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_wr_ctrl.sv
// ---------------------------------------------------------------------------
// axi_sram_wr_ctrl
//   AXI4 write-channel slave stage placed directly in front of an SRAM.
//   It accepts one AW burst at a time, consumes that burst's W beats, and
//   issues one masked single-cycle SRAM write per beat. It then returns a
//   B response. Only one burst is in flight at any time.
//
// Ports
//   ACLK, ARESETn            clock (rising edge), async active-low reset
//   AWID/AWADDR/AWLEN/
//   AWSIZE/AWBURST,
//   AWVALID/AWREADY          write address channel
//   WDATA/WSTRB/WLAST,
//   WVALID/WREADY            write data channel
//   BID/BRESP/BVALID/BREADY  write response channel
//   mem_we                   one-cycle SRAM write strobe
//   mem_addr                 SRAM word index (byte address / STRB_WIDTH)
//   mem_wdata, mem_be        SRAM write data and byte enables
//   All outputs come straight from flops.
// ---------------------------------------------------------------------------
module axi_sram_wr_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 12,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                                       ACLK,
    input  logic                                       ARESETn,
    input  logic [ID_WIDTH-1:0]                        AWID,
    input  logic [ADDR_WIDTH-1:0]                      AWADDR,
    input  logic [7:0]                                 AWLEN,
    input  logic [2:0]                                 AWSIZE,
    input  logic [1:0]                                 AWBURST,
    input  logic                                       AWVALID,
    output logic                                       AWREADY,
    input  logic [DATA_WIDTH-1:0]                      WDATA,
    input  logic [STRB_WIDTH-1:0]                      WSTRB,
    input  logic                                       WLAST,
    input  logic                                       WVALID,
    output logic                                       WREADY,
    output logic [ID_WIDTH-1:0]                        BID,
    output logic [1:0]                                 BRESP,
    output logic                                       BVALID,
    input  logic                                       BREADY,
    output logic                                       mem_we,
    output logic [ADDR_WIDTH-$clog2(STRB_WIDTH)-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]                      mem_wdata,
    output logic [STRB_WIDTH-1:0]                      mem_be
);

    localparam int LOG2_STRB = $clog2(STRB_WIDTH);
    localparam int WORD_W    = ADDR_WIDTH - LOG2_STRB;

    localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1'b1);
    localparam logic [ADDR_WIDTH-1:0] LANE_M_A  = ADDR_WIDTH'(STRB_WIDTH - 1);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    // Byte lanes lo..hi inclusive; lanes outside 0..STRB_WIDTH-1 simply drop out.
    function automatic logic [STRB_WIDTH-1:0] lane_mask(
        input logic [ADDR_WIDTH-1:0] lo,
        input logic [ADDR_WIDTH-1:0] hi
    );
        logic [STRB_WIDTH-1:0] m;
        m = {STRB_WIDTH{1'b0}};
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if ((ADDR_WIDTH'(i) >= lo) && (ADDR_WIDTH'(i) <= hi)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    // Registered state
    state_t                  state_r,     state_nxt_s;
    logic [ID_WIDTH-1:0]     id_r,        id_nxt_s;
    logic [ADDR_WIDTH-1:0]   cur_addr_r,  cur_addr_nxt_s;
    logic [7:0]              len_r,       len_nxt_s;
    logic [2:0]              size_r,      size_nxt_s;
    logic [1:0]              burst_r,     burst_nxt_s;
    logic [ADDR_WIDTH-1:0]   wrap_lo_r,   wrap_lo_nxt_s;
    logic [ADDR_WIDTH-1:0]   wrap_hi_r,   wrap_hi_nxt_s;
    logic [7:0]              beat_r,      beat_nxt_s;
    logic                    illegal_r,   illegal_nxt_s;
    logic                    err_r,       err_nxt_s;
    logic                    awready_r,   awready_nxt_s;
    logic                    wready_r,    wready_nxt_s;
    logic                    bvalid_r,    bvalid_nxt_s;
    logic [ID_WIDTH-1:0]     bid_r,       bid_nxt_s;
    logic [1:0]              bresp_r,     bresp_nxt_s;
    logic                    mem_we_r,    mem_we_nxt_s;
    logic [WORD_W-1:0]       mem_addr_r,  mem_addr_nxt_s;
    logic [DATA_WIDTH-1:0]   mem_wdata_r, mem_wdata_nxt_s;
    logic [STRB_WIDTH-1:0]   mem_be_r,    mem_be_nxt_s;

    // Capture-time helpers
    logic [3:0]              wrap_shift_s;
    logic [ADDR_WIDTH-1:0]   wrap_total_s;
    logic [ADDR_WIDTH-1:0]   wrap_lo_s;
    logic                    illegal_s;

    // Per-beat helpers
    logic [ADDR_WIDTH-1:0]   size_bytes_s;
    logic [ADDR_WIDTH-1:0]   aligned_s;
    logic [ADDR_WIDTH-1:0]   lane_lo_s;
    logic [ADDR_WIDTH-1:0]   lane_hi_s;
    logic [ADDR_WIDTH-1:0]   wrap_inc_s;
    logic [ADDR_WIDTH-1:0]   next_addr_s;
    logic [STRB_WIDTH-1:0]   beat_mask_s;
    logic                    first_mask_s;
    logic                    is_last_s;
    logic                    wlast_bad_s;

    // Wrap container and legality of the burst presented on AW
    always_comb begin
        case (AWLEN)
            8'd1:    wrap_shift_s = 4'd1;
            8'd3:    wrap_shift_s = 4'd2;
            8'd7:    wrap_shift_s = 4'd3;
            8'd15:   wrap_shift_s = 4'd4;
            default: wrap_shift_s = 4'd0;
        endcase
        // The container is size*(len+1) bytes; both factors are powers of two.
        wrap_total_s = ONE_A << ({1'b0, AWSIZE} + wrap_shift_s);
        wrap_lo_s    = AWADDR & ~(wrap_total_s - ONE_A);
        illegal_s    = (AWBURST == 2'b11) ||
                       (int'(AWSIZE) > LOG2_STRB) ||
                       ((AWBURST == BURST_WRAP) && (wrap_shift_s == 4'd0));
    end

    // Beat address, lane mask and next beat address for the current beat
    always_comb begin
        size_bytes_s = ONE_A << size_r;
        aligned_s    = cur_addr_r & ~(size_bytes_s - ONE_A);
        lane_lo_s    = cur_addr_r & LANE_M_A;
        first_mask_s = (beat_r == 8'd0) || (burst_r == BURST_FIXED);
        // The first (or FIXED) beat may start mid-transfer. Its top lane is the
        // end of the aligned transfer, measured from the word base.
        if (first_mask_s) begin
            lane_hi_s = aligned_s + size_bytes_s - ONE_A - (cur_addr_r - lane_lo_s);
        end else begin
            lane_hi_s = lane_lo_s + size_bytes_s - ONE_A;
        end
        beat_mask_s = lane_mask(lane_lo_s, lane_hi_s);

        wrap_inc_s = cur_addr_r + size_bytes_s;
        case (burst_r)
            BURST_FIXED: next_addr_s = cur_addr_r;
            BURST_INCR:  next_addr_s = aligned_s + size_bytes_s;
            BURST_WRAP: begin
                if (wrap_inc_s == wrap_hi_r) begin
                    next_addr_s = wrap_lo_r;
                end else begin
                    next_addr_s = wrap_inc_s;
                end
            end
            default:     next_addr_s = cur_addr_r;
        endcase

        is_last_s   = (beat_r == len_r);
        wlast_bad_s = (WLAST != is_last_s);
    end

    // Next-state and next-output logic of the burst FSM
    always_comb begin
        state_nxt_s     = state_r;
        id_nxt_s        = id_r;
        cur_addr_nxt_s  = cur_addr_r;
        len_nxt_s       = len_r;
        size_nxt_s      = size_r;
        burst_nxt_s     = burst_r;
        wrap_lo_nxt_s   = wrap_lo_r;
        wrap_hi_nxt_s   = wrap_hi_r;
        beat_nxt_s      = beat_r;
        illegal_nxt_s   = illegal_r;
        err_nxt_s       = err_r;
        awready_nxt_s   = awready_r;
        wready_nxt_s    = wready_r;
        bvalid_nxt_s    = bvalid_r;
        bid_nxt_s       = bid_r;
        bresp_nxt_s     = bresp_r;
        mem_we_nxt_s    = 1'b0;
        mem_addr_nxt_s  = mem_addr_r;
        mem_wdata_nxt_s = mem_wdata_r;
        mem_be_nxt_s    = mem_be_r;

        case (state_r)
            IDLE: begin
                awready_nxt_s = 1'b1;
                if (AWVALID && awready_r) begin
                    id_nxt_s       = AWID;
                    cur_addr_nxt_s = AWADDR;
                    len_nxt_s      = AWLEN;
                    size_nxt_s     = AWSIZE;
                    burst_nxt_s    = AWBURST;
                    wrap_lo_nxt_s  = wrap_lo_s;
                    wrap_hi_nxt_s  = wrap_lo_s + wrap_total_s;
                    beat_nxt_s     = 8'd0;
                    illegal_nxt_s  = illegal_s;
                    err_nxt_s      = 1'b0;
                    awready_nxt_s  = 1'b0;
                    wready_nxt_s   = 1'b1;
                    state_nxt_s    = DATA;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            DATA: begin
                if (WVALID && wready_r) begin
                    mem_we_nxt_s    = ~illegal_r;
                    mem_addr_nxt_s  = cur_addr_r[ADDR_WIDTH-1:LOG2_STRB];
                    mem_wdata_nxt_s = WDATA;
                    mem_be_nxt_s    = WSTRB & beat_mask_s;
                    cur_addr_nxt_s  = next_addr_s;
                    beat_nxt_s      = beat_r + 8'd1;
                    err_nxt_s       = err_r | wlast_bad_s;
                    // AWLEN, not WLAST, ends the burst.
                    if (is_last_s) begin
                        wready_nxt_s = 1'b0;
                        bvalid_nxt_s = 1'b1;
                        bid_nxt_s    = id_r;
                        if (illegal_r || err_r || wlast_bad_s) begin
                            bresp_nxt_s = RESP_SLVERR;
                        end else begin
                            bresp_nxt_s = RESP_OKAY;
                        end
                        state_nxt_s  = RESP;
                    end else begin
                        state_nxt_s  = DATA;
                    end
                end else begin
                    state_nxt_s = DATA;
                end
            end
            RESP: begin
                if (bvalid_r && BREADY) begin
                    bvalid_nxt_s  = 1'b0;
                    awready_nxt_s = 1'b1;
                    state_nxt_s   = IDLE;
                end else begin
                    state_nxt_s   = RESP;
                end
            end
            default: begin
                awready_nxt_s = 1'b0;
                wready_nxt_s  = 1'b0;
                bvalid_nxt_s  = 1'b0;
                state_nxt_s   = IDLE;
            end
        endcase
    end

    // State, captured burst and output registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_r     <= IDLE;
            id_r        <= {ID_WIDTH{1'b0}};
            cur_addr_r  <= {ADDR_WIDTH{1'b0}};
            len_r       <= 8'd0;
            size_r      <= 3'd0;
            burst_r     <= 2'b00;
            wrap_lo_r   <= {ADDR_WIDTH{1'b0}};
            wrap_hi_r   <= {ADDR_WIDTH{1'b0}};
            beat_r      <= 8'd0;
            illegal_r   <= 1'b0;
            err_r       <= 1'b0;
            awready_r   <= 1'b0;
            wready_r    <= 1'b0;
            bvalid_r    <= 1'b0;
            bid_r       <= {ID_WIDTH{1'b0}};
            bresp_r     <= 2'b00;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {WORD_W{1'b0}};
            mem_wdata_r <= {DATA_WIDTH{1'b0}};
            mem_be_r    <= {STRB_WIDTH{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            id_r        <= id_nxt_s;
            cur_addr_r  <= cur_addr_nxt_s;
            len_r       <= len_nxt_s;
            size_r      <= size_nxt_s;
            burst_r     <= burst_nxt_s;
            wrap_lo_r   <= wrap_lo_nxt_s;
            wrap_hi_r   <= wrap_hi_nxt_s;
            beat_r      <= beat_nxt_s;
            illegal_r   <= illegal_nxt_s;
            err_r       <= err_nxt_s;
            awready_r   <= awready_nxt_s;
            wready_r    <= wready_nxt_s;
            bvalid_r    <= bvalid_nxt_s;
            bid_r       <= bid_nxt_s;
            bresp_r     <= bresp_nxt_s;
            mem_we_r    <= mem_we_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
            mem_be_r    <= mem_be_nxt_s;
        end
    end

    assign AWREADY   = awready_r;
    assign WREADY    = wready_r;
    assign BVALID    = bvalid_r;
    assign BID       = bid_r;
    assign BRESP     = bresp_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_be    = mem_be_r;

endmodule

// File: tb/tb_axi_sram_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_wr_ctrl
//   Directed bench for axi_sram_wr_ctrl (default 32-bit data, 16-bit address).
//   Inputs change 1 time unit after the rising edge, and outputs are sampled
//   there too. SRAM writes are logged on the falling edge.
// ---------------------------------------------------------------------------
module tb_axi_sram_wr_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [11:0] AWID;
    logic [15:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [11:0] BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;

    int checks   = 0;
    int failures = 0;

    logic [13:0] log_addr [0:63];
    logic [3:0]  log_be   [0:63];
    logic [31:0] log_data [0:63];
    logic        log_bv   [0:63];
    int          wr_cnt = 0;

    axi_sram_wr_ctrl dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .AWID      (AWID),
        .AWADDR    (AWADDR),
        .AWLEN     (AWLEN),
        .AWSIZE    (AWSIZE),
        .AWBURST   (AWBURST),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .WLAST     (WLAST),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BID       (BID),
        .BRESP     (BRESP),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be)
    );

    always #5 ACLK = ~ACLK;

    // Log every SRAM write together with BVALID in the same cycle
    always @(negedge ACLK) begin
        if (mem_we === 1'b1 && wr_cnt < 64) begin
            log_addr[wr_cnt] <= mem_addr;
            log_be[wr_cnt]   <= mem_be;
            log_data[wr_cnt] <= mem_wdata;
            log_bv[wr_cnt]   <= BVALID;
            wr_cnt           <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [13:0] ea, input logic [3:0] ebe);
        check({tag, "_addr"}, 64'(log_addr[idx]), 64'(ea));
        check({tag, "_be"},   64'(log_be[idx]),   64'(ebe));
    endtask

    task automatic send_aw(input logic [11:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit done;
        done    = 1'b0;
        AWID    = id;
        AWADDR  = addr;
        AWLEN   = len;
        AWSIZE  = size;
        AWBURST = burst;
        AWVALID = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (AWREADY === 1'b1) done = 1'b1;
            @(posedge ACLK); #1;
        end
        AWVALID = 1'b0;
        check("aw_handshake", 64'(done), 64'(1'b1));
        check("wready_after_aw", 64'(WREADY), 64'(1'b1));
        check("awready_after_aw", 64'(AWREADY), 64'(1'b0));
    endtask

    task automatic send_beats(input int n, input int last_at, input int gap_after,
                              input logic [3:0] strb, input logic [31:0] dbase, input logic wready_end);
        bit done;
        for (int k = 0; k < n; k++) begin
            WVALID = 1'b1;
            WDATA  = dbase + 32'(k);
            WSTRB  = strb;
            WLAST  = (k == last_at);
            done   = 1'b0;
            for (int i = 0; i < 20 && !done; i++) begin
                if (WREADY === 1'b1) done = 1'b1;
                @(posedge ACLK); #1;
            end
            check("w_handshake", 64'(done), 64'(1'b1));
            if (k == gap_after) begin
                WVALID = 1'b0;
                @(posedge ACLK); #1;
                check("gap_no_write", 64'(mem_we), 64'(1'b0));
            end
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        check("wready_end", 64'(WREADY), 64'(wready_end));
    endtask

    task automatic finish_b(input logic [11:0] exp_id, input logic [1:0] exp_resp, input int stall);
        check("bvalid_latency", 64'(BVALID), 64'(1'b1));
        check("bid", 64'(BID), 64'(exp_id));
        check("bresp", 64'(BRESP), 64'(exp_resp));
        for (int s = 0; s < stall; s++) begin
            @(posedge ACLK); #1;
            check("stall_bvalid", 64'(BVALID), 64'(1'b1));
            check("stall_bid", 64'(BID), 64'(exp_id));
            check("stall_bresp", 64'(BRESP), 64'(exp_resp));
            check("stall_awready", 64'(AWREADY), 64'(1'b0));
        end
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        check("bvalid_drop", 64'(BVALID), 64'(1'b0));
        check("awready_return", 64'(AWREADY), 64'(1'b1));
    endtask

    initial begin
        int base;
        ARESETn = 1'b0;
        AWID = 12'h000; AWADDR = 16'h0000; AWLEN = 8'd0; AWSIZE = 3'd0; AWBURST = 2'b00;
        AWVALID = 1'b0; WDATA = 32'h0; WSTRB = 4'h0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;

        // Reset state
        @(posedge ACLK); @(posedge ACLK); #1;
        check("rst_awready", 64'(AWREADY), 64'(1'b0));
        check("rst_wready", 64'(WREADY), 64'(1'b0));
        check("rst_bvalid", 64'(BVALID), 64'(1'b0));
        check("rst_mem_we", 64'(mem_we), 64'(1'b0));
        @(negedge ACLK) ARESETn = 1'b1;
        @(posedge ACLK); #1;
        check("awready_after_release", 64'(AWREADY), 64'(1'b1));

        // 1. INCR aligned
        base = wr_cnt;
        send_aw(12'h5A3, 16'h0100, 8'd3, 3'd2, 2'b01);
        send_beats(4, 3, -1, 4'hF, 32'hA000_0000, 1'b0);
        finish_b(12'h5A3, 2'b00, 0);
        check("t1_count", 64'(wr_cnt - base), 64'd4);
        check_wr("t1_b0", base + 0, 14'h040, 4'hF);
        check_wr("t1_b1", base + 1, 14'h041, 4'hF);
        check_wr("t1_b2", base + 2, 14'h042, 4'hF);
        check_wr("t1_b3", base + 3, 14'h043, 4'hF);
        check("t1_data1", 64'(log_data[base + 1]), 64'h0000_0000_A000_0001);
        check("t1_last_with_bvalid", 64'(log_bv[base + 3]), 64'(1'b1));
        check("t1_prev_no_bvalid", 64'(log_bv[base + 2]), 64'(1'b0));

        // 2. INCR unaligned narrow
        base = wr_cnt;
        send_aw(12'h011, 16'h0003, 8'd2, 3'd1, 2'b01);
        send_beats(3, 2, -1, 4'hF, 32'hB000_0000, 1'b0);
        finish_b(12'h011, 2'b00, 0);
        check("t2_count", 64'(wr_cnt - base), 64'd3);
        check_wr("t2_b0", base + 0, 14'h000, 4'b1000);
        check_wr("t2_b1", base + 1, 14'h001, 4'b0011);
        check_wr("t2_b2", base + 2, 14'h001, 4'b1100);

        // 3. WRAP, with a WVALID gap after beat 1
        base = wr_cnt;
        send_aw(12'h022, 16'h0034, 8'd3, 3'd2, 2'b10);
        send_beats(4, 3, 1, 4'hF, 32'hC000_0000, 1'b0);
        finish_b(12'h022, 2'b00, 0);
        check("t3_count", 64'(wr_cnt - base), 64'd4);
        check_wr("t3_b0", base + 0, 14'h00D, 4'hF);
        check_wr("t3_b1", base + 1, 14'h00E, 4'hF);
        check_wr("t3_b2", base + 2, 14'h00F, 4'hF);
        check_wr("t3_b3", base + 3, 14'h00C, 4'hF);

        // 4. FIXED
        base = wr_cnt;
        send_aw(12'h033, 16'h0012, 8'd2, 3'd1, 2'b00);
        send_beats(3, 2, -1, 4'hF, 32'hD000_0000, 1'b0);
        finish_b(12'h033, 2'b00, 0);
        check("t4_count", 64'(wr_cnt - base), 64'd3);
        check_wr("t4_b0", base + 0, 14'h004, 4'b1100);
        check_wr("t4_b1", base + 1, 14'h004, 4'b1100);
        check_wr("t4_b2", base + 2, 14'h004, 4'b1100);

        // 5a. Early WLAST
        base = wr_cnt;
        send_aw(12'h044, 16'h0200, 8'd3, 3'd2, 2'b01);
        send_beats(4, 1, -1, 4'hF, 32'hE000_0000, 1'b0);
        finish_b(12'h044, 2'b10, 0);
        check("t5a_count", 64'(wr_cnt - base), 64'd4);

        // 5b. Reserved burst type
        base = wr_cnt;
        send_aw(12'h055, 16'h0300, 8'd1, 3'd2, 2'b11);
        send_beats(2, 1, -1, 4'hF, 32'hE100_0000, 1'b0);
        finish_b(12'h055, 2'b10, 0);
        check("t5b_count", 64'(wr_cnt - base), 64'd0);

        // 5c. WRAP with illegal length
        base = wr_cnt;
        send_aw(12'h066, 16'h0040, 8'd2, 3'd2, 2'b10);
        send_beats(3, 2, -1, 4'hF, 32'hE200_0000, 1'b0);
        finish_b(12'h066, 2'b10, 0);
        check("t5c_count", 64'(wr_cnt - base), 64'd0);

        // 6a. BREADY held low for 5 cycles
        base = wr_cnt;
        send_aw(12'h077, 16'h0010, 8'd0, 3'd2, 2'b01);
        send_beats(1, 0, -1, 4'hF, 32'hF000_0000, 1'b0);
        finish_b(12'h077, 2'b00, 5);
        check("t6a_count", 64'(wr_cnt - base), 64'd1);
        check_wr("t6a_b0", base + 0, 14'h004, 4'hF);

        // 6b. Reset mid-burst, after beat 1
        send_aw(12'h088, 16'h0400, 8'd3, 3'd2, 2'b01);
        send_beats(2, 3, -1, 4'hF, 32'hF100_0000, 1'b1);
        #1 ARESETn = 1'b0;
        #1;
        check("mid_rst_awready", 64'(AWREADY), 64'(1'b0));
        check("mid_rst_wready", 64'(WREADY), 64'(1'b0));
        check("mid_rst_bvalid", 64'(BVALID), 64'(1'b0));
        check("mid_rst_mem_we", 64'(mem_we), 64'(1'b0));
        check("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
        check("mid_rst_mem_be", 64'(mem_be), 64'd0);
        check("mid_rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("mid_rst_bid", 64'(BID), 64'd0);
        check("mid_rst_bresp", 64'(BRESP), 64'd0);
        @(posedge ACLK);
        @(negedge ACLK) ARESETn = 1'b1;
        @(posedge ACLK); #1;
        check("post_rst_awready", 64'(AWREADY), 64'(1'b1));
        check("post_rst_bvalid", 64'(BVALID), 64'(1'b0));
        base = wr_cnt;
        send_aw(12'h099, 16'h0500, 8'd1, 3'd2, 2'b01);
        send_beats(2, 1, -1, 4'h3, 32'hF200_0000, 1'b0);
        finish_b(12'h099, 2'b00, 0);
        check("t6b_count", 64'(wr_cnt - base), 64'd2);
        check_wr("t6b_b0", base + 0, 14'h140, 4'h3);
        check_wr("t6b_b1", base + 1, 14'h141, 4'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
